// File: rtl/code_decoder_pipe_pkg.sv
// Shared definitions for the code decoder pipe.
//   CODE_W    : width of the binary input code
//   OUT_W     : width of the one-hot output word; legal codes are 0..OUT_W-1
//   ERR_CNT_W : width of the saturating illegal-code counter
//   occ_e     : FIFO occupancy state (EMPTY / ONE / FULL)
//   entry_t   : one buffered result (one-hot word plus error flag)
//   code_is_legal() : bound check shared by decoder and anything else
package code_decoder_pipe_pkg;

  localparam int CODE_W    = 5;
  localparam int OUT_W     = 20;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [OUT_W-1:0] onehot;
    logic             err;
  } entry_t;

  function automatic logic code_is_legal(input logic [CODE_W-1:0] code);
    return int'(code) < OUT_W;
  endfunction

endpackage

// File: rtl/code_decoder_pipe_if.sv
// Handshake bundle for the code decoder pipe.
//   in_valid/in_ready/in_code         : code input, valid/ready
//   out_valid/out_ready               : result output, valid/ready
//   out_onehot/out_err                : FIFO head contents
//   err_count                         : saturating count of illegal codes
// Modports: slave = the decoder itself, master = the surrounding logic
// that supplies codes and consumes results.
interface code_decoder_pipe_if;
  import code_decoder_pipe_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [CODE_W-1:0]    in_code;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_onehot;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_onehot, out_err, err_count
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_onehot, out_err, err_count
  );

endinterface

// File: rtl/code_decoder_pipe_onehot_expand.sv
// Purely combinational binary-to-one-hot expander.
//   code    : CODE_W-bit binary code
//   onehot  : OUT_W-bit word with bit 'code' set; all zero for illegal codes
//   illegal : high when code >= OUT_W
module code_decoder_pipe_onehot_expand
  import code_decoder_pipe_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [OUT_W-1:0]  onehot,
  output logic              illegal
);

  // Codes past OUT_W-1 match no bit position, so the word comes out all zero
  // without needing a separate masking step.
  always_comb begin
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = (int'(code) == i);
    end
    illegal = !code_is_legal(code);
  end

endmodule

// File: rtl/code_decoder_pipe.sv
// Code decoder pipe: accepts binary codes over valid/ready, expands each to
// a one-hot word and buffers results in a 2-entry FIFO.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; flushes the FIFO and error counter
//   bus   : code_decoder_pipe_if.slave handshake bundle
// The head entry lives in a dedicated output register so out_onehot/out_err
// are glitch-free, stay put under backpressure, and keep the last popped
// value when the FIFO drains. in_ready/out_valid decode only the registered
// occupancy state, so there is no combinational path from out_ready.
module code_decoder_pipe
  import code_decoder_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  code_decoder_pipe_if.slave bus
);

  occ_e                 state_q, state_d;
  entry_t               mem [2];
  logic                 wr_ptr_q, rd_ptr_q;
  entry_t               head_q, head_d;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic                 in_ready, out_valid;
  logic                 push, pop;
  logic [OUT_W-1:0]     dec_onehot;
  logic                 dec_illegal;
  entry_t               new_entry;

  code_decoder_pipe_onehot_expand u_expand (
    .code    (bus.in_code),
    .onehot  (dec_onehot),
    .illegal (dec_illegal)
  );

  assign new_entry = '{onehot: dec_onehot, err: dec_illegal};

  assign in_ready = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push = bus.in_valid && in_ready;
  assign pop  = out_valid && bus.out_ready;

  // Next occupancy and next head. The head changes only when a new entry
  // becomes the oldest one: a push into an empty FIFO, a push that coincides
  // with popping the sole entry, or a pop that exposes the second entry.
  // NOTE: every output of a combinational block gets a default before the
  // case statement; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = new_entry;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (pop) begin
          state_d = EMPTY;
        end else if (push) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = mem[~rd_ptr_q];
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      head_q      <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (push && dec_illegal && (err_count_q != '1)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, and the visible head comes from head_q, which is reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= new_entry;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_onehot = head_q.onehot;
  assign bus.out_err    = head_q.err;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_code_decoder_pipe.sv
// Directed bench for code_decoder_pipe with a queue-based scoreboard.
module tb_code_decoder_pipe;
  import code_decoder_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  code_decoder_pipe_if bus ();

  code_decoder_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  entry_t      sb_q[$];
  entry_t      last_pop;
  int unsigned exp_err;
  int          n_total = 0;
  int          n_pass  = 0;

  function automatic entry_t model(input int code);
    entry_t e;
    e.onehot = '0;
    e.err    = 1'b0;
    if (code < OUT_W) e.onehot[code] = 1'b1;
    else              e.err = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(sb_q.size() < 2));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sb_q.size() > 0));
    check({tag, ".err_count"}, 32'(bus.err_count), exp_err);
    if (sb_q.size() > 0) begin
      check({tag, ".head_onehot"}, 32'(bus.out_onehot), 32'(sb_q[0].onehot));
      check({tag, ".head_err"},    32'(bus.out_err),    32'(sb_q[0].err));
    end else begin
      check({tag, ".idle_onehot"}, 32'(bus.out_onehot), 32'(last_pop.onehot));
      check({tag, ".idle_err"},    32'(bus.out_err),    32'(last_pop.err));
    end
  endtask

  // One clock with the given inputs; scoreboard is updated from the model's
  // own occupancy, then DUT state is compared just after the edge.
  task automatic step(input logic v, input int code, input logic r, input string tag);
    logic do_push, do_pop;
    bus.in_valid  = v;
    bus.in_code   = CODE_W'(code);
    bus.out_ready = r;
    do_push = v && (sb_q.size() < 2);
    do_pop  = r && (sb_q.size() > 0);
    if (do_pop) last_pop = sb_q.pop_front();
    if (do_push) begin
      sb_q.push_back(model(code));
      if (code >= OUT_W && exp_err < 255) exp_err++;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    check({tag, ".rst_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".rst_err_count"}, 32'(bus.err_count), 32'd0);
    sb_q.delete();
    last_pop = '0;
    exp_err  = 0;
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_state(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b0;
    last_pop = '0;
    exp_err  = 0;

    // Reset then idle
    do_reset(2, "reset");
    step(0, 0, 0, "idle");
    check("idle.onehot_zero", 32'(bus.out_onehot), 32'h0);

    // Single legal codes, each accepted then drained
    step(1, 7, 1, "code7");
    check("code7.onehot", 32'(bus.out_onehot), 32'h00080);
    step(0, 0, 1, "code7_pop");
    step(1, 0, 1, "code0");
    check("code0.onehot", 32'(bus.out_onehot), 32'h00001);
    step(0, 0, 1, "code0_pop");
    step(1, 19, 1, "code19");
    check("code19.onehot", 32'(bus.out_onehot), 32'h80000);
    step(0, 0, 1, "code19_pop");

    // Illegal codes
    step(1, 20, 0, "ill20");
    step(1, 31, 0, "ill31");
    check("ill.err_count2", 32'(bus.err_count), 32'd2);
    step(0, 0, 1, "ill_pop0");
    step(0, 0, 1, "ill_pop1");

    // Counter saturation
    for (int i = 0; i < 300; i++) step(1, 20 + (i % 12), 1, "ill_sat");
    check("ill_sat.err_count255", 32'(bus.err_count), 32'd255);
    step(0, 0, 1, "ill_sat_drain");
    step(1, 25, 1, "ill_sat_hold");
    check("ill_sat.held", 32'(bus.err_count), 32'd255);
    step(0, 0, 1, "ill_sat_drain2");

    // Backpressure and full
    step(1, 3, 0, "bp_push3");
    step(1, 9, 0, "bp_push9");
    check("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
    step(1, 4, 0, "bp_reject4");
    step(0, 0, 1, "bp_pop0");
    check("bp.second_head", 32'(bus.out_onehot), 32'h00200);
    step(0, 0, 1, "bp_pop1");
    check("bp.idle_last", 32'(bus.out_onehot), 32'h00200);
    step(0, 0, 1, "bp_empty");

    // Simultaneous push and pop at count 1
    step(1, 2, 0, "pp_fill");
    check("pp.head2", 32'(bus.out_onehot), 32'h00004);
    step(1, 11, 1, "pp_both");
    check("pp.head11", 32'(bus.out_onehot), 32'h00800);
    check("pp.in_ready", 32'(bus.in_ready), 32'd1);
    step(0, 0, 1, "pp_drain");

    // Reset mid-operation with count 2 and err_count 5
    do_reset(1, "reset2");
    for (int i = 0; i < 5; i++) step(1, 21 + i, 1, "mid_err");
    step(0, 0, 1, "mid_drain");
    step(1, 1, 0, "mid_fill1");
    step(1, 2, 0, "mid_fill2");
    check("mid.err5", 32'(bus.err_count), 32'd5);
    bus.in_valid  = 1'b1;
    bus.in_code   = 5'd3;
    bus.out_ready = 1'b1;
    do_reset(1, "mid_reset");
    for (int i = 0; i < 3; i++) step(0, 0, 1, "post_reset_idle");
    step(1, 6, 0, "post_reset_push");
    check("post_reset.head6", 32'(bus.out_onehot), 32'h00040);
    step(0, 0, 1, "post_reset_pop");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/code_decoder_pipe.md
Name: code_decoder_pipe

Overview:
Inverse partner of the 20→10→5 encode path. Accepts 5-bit binary codes over a valid/ready handshake and expands each one to a 20-bit one-hot word, using the same bit mapping as the Decoder5x20 stage (code k → bit k).
Results are buffered in a 2-entry FIFO with valid/ready output. Codes 20..31 are flagged as errors and counted. Sits on the receive side, feeding one-hot words back into the Pipo20 domain.

Parameters:
CODE_W, 5, width of input code
OUT_W, 20, one-hot output width; legal codes are 0..OUT_W-1
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_code is valid this cycle
in_ready  out  1  block can accept a code this cycle
in_code  in  CODE_W  binary code to expand
out_valid  out  1  FIFO head is valid
out_ready  in  1  consumer takes head this cycle
out_onehot  out  OUT_W  decoded one-hot word at FIFO head
out_err  out  1  head entry came from an illegal code (≥ OUT_W)
err_count  out  ERR_CNT_W  number of illegal codes accepted, saturating

Behaviour:
- Reset is synchronous and active-high; clock port is clk, reset port is reset.
- Reset values on the edge where reset=1:
  - FIFO count = 0, rd/wr pointers = 0
  - out_valid = 0, out_onehot = 0, out_err = 0, err_count = 0
  - in_ready = 1 from the first cycle after reset deasserts
- Reset mid-operation discards all buffered entries. in_valid and out_ready are ignored while reset=1.
- Accept rule: push when in_valid & in_ready. Pop when out_valid & out_ready.
- in_ready = (count < 2). It is derived only from registered state; there is no combinational path from out_ready.
- Decode at push:
  - in_code < OUT_W: entry = one-hot with bit in_code set, err = 0.
  - Otherwise: entry = all-zero word, err = 1.
- Latency: a code accepted at edge N appears on out_onehot/out_valid in the cycle after edge N (1 cycle).
- FIFO is 2 entries with wrap-around pointers (1-bit index).
- Count update per cycle:
  - push only: +1
  - pop only: −1
  - push and pop together (legal only at count=1): count unchanged; head advances, new entry written at tail
  - count=2: in_ready=0, so no push is possible
  - count=0: out_valid=0, so no pop is possible
- out_onehot/out_err always reflect the head entry. When count=0 they hold the last popped values; consumers must qualify them with out_valid.
- err_count increments by 1 on each accepted illegal code and saturates at 2^ERR_CNT_W−1 (255); it never wraps. It is not cleared by reads, only by reset.
- Output stability: while out_valid=1 and out_ready=0, out_onehot and out_err hold constant.
- Internal state machine (FIFO occupancy):
  - EMPTY → ONE on push
  - ONE → EMPTY on pop without push
  - ONE → FULL on push without pop
  - ONE → ONE on push and pop together
  - FULL → ONE on pop
  - Any state → EMPTY on reset
- Invariants: out_onehot has at most 1 bit set, and exactly 1 bit set when out_err=0.

Decomposition:
- Shared package holds:
  - constants CODE_W=5, OUT_W=20, ERR_CNT_W=8
  - occupancy state encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2
  - function for the legal-code bound check
- One natural sub-module: onehot_expand. It is purely combinational and maps CODE_W → OUT_W one-hot plus an illegal flag. It is reused for the push-side decode.
- The FIFO and counter stay in the top module.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then 0 → out_valid=0, err_count=0, in_ready=1, out_onehot=20'h00000.
- Single legal code: in_code=5'd7 with in_valid=1 and out_ready=1 for 1 cycle → next cycle out_valid=1, out_onehot=20'h00080, out_err=0. Repeat for code 0 → 20'h00001 and code 19 → 20'h80000.
- Illegal codes: push 5'd20 then 5'd31 → out_onehot=20'h00000 with out_err=1 for both entries, err_count=2. Then push 300 illegal codes → err_count=255, held at 255.
- Backpressure/full: out_ready=0, push 3 then 9 → in_ready=0 after the 2nd push; a 3rd push attempt (code 4) is not accepted. Raise out_ready → pops in order 20'h00008, 20'h00200 with no loss or duplication.
- Simultaneous push/pop at count=1: hold count=1 (head=code 2), drive in_valid=1 (code 11) and out_ready=1 → head becomes 20'h00800, count stays 1, in_ready stays 1.
- Reset mid-operation: with count=2 and err_count=5, assert reset for 1 cycle → out_valid=0, err_count=0, in_ready=1 next cycle; the old entries never appear on the output.
